lock_sequencer: RTL

//  Top-level unlock controller for the six-digit lock.
//  - Collects three two-digit entry pairs into a 24-bit attempt buffer.
//  - Scans the password slots one per cycle through a single shared comparator.
//  - Drives unlock / fail / lockout; counts failed attempts; flashes the alarm LED.

---
 rtl/lock_pkg.sv | 27 ++
 rtl/lock_timer.sv | 37 +++
 rtl/lock_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the six-digit lock sequencer.
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PAIR_W  = 2 * DIGIT_W;
  localparam int unsigned PW_W    = 24;
  localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hE;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    FAIL,
    UNLOCK,
    LOCKOUT
  } state_t;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(9);
  endfunction

  // Non-BCD digits are stored as ERR_DIGIT so they can never match a real slot.
  function automatic logic [DIGIT_W-1:0] digit_fix(input logic [DIGIT_W-1:0] d);
    return digit_bad(d) ? ERR_DIGIT : d;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // done is registered from the next count so it always equals (cnt_q == 0).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/lock_sequencer.sv
// Six-digit lock controller: pair entry, one-slot-per-cycle compare, unlock/fail/lockout.
// Define LOCK_SEQ_TIMEOUT_EN to enable the ENTRY inactivity timeout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned MAX_ERR        = 3,
  parameter int unsigned UNLOCK_CYCLES  = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 5000,
  parameter int unsigned FLASH_HALF     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned EW = (MAX_ERR > 0) ? $clog2(MAX_ERR + 1) : 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            pair_vld,
  input  logic [3:0]      pair_a,
  input  logic [3:0]      pair_b,
  input  logic            cancel,
  output logic [SW-1:0]   slot_sel,
  input  logic [PW_W-1:0] slot_data,
  input  logic            slot_en,
  output logic            busy,
  output logic [1:0]      entry_cnt,
  output logic            bad_digit,
  output logic            unlock,
  output logic            lockout,
  output logic [EW-1:0]   err_cnt,
  output logic            led
);

  localparam int unsigned T_MAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned T_MAX   = (T_MAX_A > TIMEOUT_CYCLES) ? T_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(T_MAX + 1);
  localparam int unsigned FW      = $clog2(FLASH_HALF + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(MAX_ERR);

  state_t          state_q, state_d;
  logic [PW_W-1:0] buf_q, buf_d;
  logic            poison_q, poison_d;
  logic [1:0]      entry_cnt_q, entry_cnt_d;
  logic [SW-1:0]   slot_sel_q, slot_sel_d;
  logic [EW-1:0]   err_q, err_d;
  logic            busy_q, busy_d, bad_q, bad_d;
  logic            unlock_q, unlock_d, lockout_q, lockout_d, led_q, led_d;

  logic            tmr_load, tmr_done, fl_load, fl_done;
  logic [TW-1:0]   tmr_val;
  logic [PAIR_W-1:0] pair_w;
  logic            pair_bad, match;

  assign pair_w   = {digit_fix(pair_a), digit_fix(pair_b)};
  assign pair_bad = digit_bad(pair_a) | digit_bad(pair_b);
  assign match    = slot_en && (slot_data == buf_q) && !poison_q;

  lock_timer #(.W(TW)) u_main_tmr (
    .clk(clk), .clr(clr), .load_i(tmr_load), .load_val_i(tmr_val), .done_o(tmr_done)
  );

  lock_timer #(.W(FW)) u_flash_tmr (
    .clk(clk), .clr(clr), .load_i(fl_load), .load_val_i(FW'(FLASH_HALF - 1)), .done_o(fl_done)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    poison_d    = poison_q;
    entry_cnt_d = entry_cnt_q;
    slot_sel_d  = '0;
    err_d       = err_q;
    bad_d       = 1'b0;
    unlock_d    = 1'b0;
    lockout_d   = 1'b0;
    led_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    fl_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pair_vld && !cancel) begin
          buf_d       = {pair_w, 16'h0000};
          poison_d    = pair_bad;
          bad_d       = pair_bad;
          entry_cnt_d = 2'd1;
          state_d     = ENTRY;
`ifdef LOCK_SEQ_TIMEOUT_EN
          tmr_load    = 1'b1;
          tmr_val     = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ENTRY: begin
        if (cancel) begin
          buf_d       = '0;
          poison_d    = 1'b0;
          entry_cnt_d = 2'd0;
          state_d     = IDLE;
        end else if (pair_vld) begin
          case (entry_cnt_q)
            2'd1:    buf_d[15:8] = pair_w;
            default: buf_d[7:0]  = pair_w;
          endcase
          poison_d = poison_q | pair_bad;
          bad_d    = pair_bad;
          if (entry_cnt_q == 2'd2) begin
            entry_cnt_d = 2'd0;
            state_d     = CHECK;
          end else begin
            entry_cnt_d = entry_cnt_q + 2'd1;
`ifdef LOCK_SEQ_TIMEOUT_EN
            tmr_load    = 1'b1;
            tmr_val     = TW'(TIMEOUT_CYCLES - 1);
`endif
          end
`ifdef LOCK_SEQ_TIMEOUT_EN
        end else if (tmr_done) begin
          buf_d       = '0;
          poison_d    = 1'b0;
          entry_cnt_d = 2'd0;
          state_d     = FAIL;
`endif
        end
      end
      CHECK: begin
        if (match) begin
          err_d    = '0;
          unlock_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(UNLOCK_CYCLES - 1);
          buf_d    = '0;
          poison_d = 1'b0;
          state_d  = UNLOCK;
        end else if (slot_sel_q == SLOT_LAST) begin
          buf_d    = '0;
          poison_d = 1'b0;
          state_d  = FAIL;
        end else begin
          slot_sel_d = slot_sel_q + SW'(1);
        end
      end
      FAIL: begin
        err_d = (err_q >= ERR_MAX) ? ERR_MAX : err_q + EW'(1);
        if (err_d == ERR_MAX) begin
          lockout_d = 1'b1;
          led_d     = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TW'(LOCKOUT_CYCLES - 1);
          fl_load   = 1'b1;
          state_d   = LOCKOUT;
        end else begin
          state_d = IDLE;
        end
      end
      UNLOCK: begin
        if (cancel || tmr_done) begin
          state_d = IDLE;
        end else begin
          unlock_d = 1'b1;
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          err_d   = '0;
          state_d = IDLE;
        end else begin
          lockout_d = 1'b1;
          led_d     = fl_done ? ~led_q : led_q;
          fl_load   = fl_done;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CHECK) || (state_d == FAIL) ||
             (state_d == UNLOCK) || (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      poison_q    <= 1'b0;
      entry_cnt_q <= 2'd0;
      slot_sel_q  <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      bad_q       <= 1'b0;
      unlock_q    <= 1'b0;
      lockout_q   <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      poison_q    <= poison_d;
      entry_cnt_q <= entry_cnt_d;
      slot_sel_q  <= slot_sel_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      bad_q       <= bad_d;
      unlock_q    <= unlock_d;
      lockout_q   <= lockout_d;
      led_q       <= led_d;
    end
  end

  assign slot_sel  = slot_sel_q;
  assign busy      = busy_q;
  assign entry_cnt = entry_cnt_q;
  assign bad_digit = bad_q;
  assign unlock    = unlock_q;
  assign lockout   = lockout_q;
  assign err_cnt   = err_q;
  assign led       = led_q;

endmodule
